// File: rtl/ofmap_pkg.sv
// Shared types and geometry for the OFMap accumulation controller.
// Optional ReLU on final passes is enabled by defining OFMAP_RELU_EN.
package ofmap_pkg;
  localparam int MAC_COL           = 16;
  localparam int OFMAP_BITWIDTH    = 32;
  localparam int OFMAP_ADDR_BIT    = 10;
  localparam int OFMAP_CHANNEL_NUM = 64;
  localparam int OFMAP_WIDTH       = 14;
  localparam int OFMAP_HEIGHT      = 14;
  localparam int OFMAP_PIXELS      = OFMAP_WIDTH * OFMAP_HEIGHT;
  localparam int ROW_W             = MAC_COL * OFMAP_BITWIDTH;
  localparam int CH_BLKS           = OFMAP_CHANNEL_NUM / MAC_COL;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH
  } state_t;

  typedef logic [OFMAP_BITWIDTH-1:0] lane_t;
  typedef logic [ROW_W-1:0]          row_t;
  typedef logic [OFMAP_ADDR_BIT-1:0] addr_t;

  function automatic lane_t lane_of(row_t row, int i);
    return row[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH];
  endfunction
endpackage

// File: rtl/ofmap_accum_controller_psum_lane_adder.sv
// One psum lane: forwarding mux, modulo add, optional final-pass ReLU.
// ReLU clamp is compiled in only when OFMAP_RELU_EN is defined.
module psum_lane_adder
  import ofmap_pkg::*;
(
  input  logic [OFMAP_BITWIDTH-1:0] psum,
  input  logic [OFMAP_BITWIDTH-1:0] rdata,
  input  logic [OFMAP_BITWIDTH-1:0] fwd_data,
  input  logic                      fwd_sel,
  input  logic                      first_pass,
  input  logic                      last_pass,
  output logic [OFMAP_BITWIDTH-1:0] sum
);
  lane_t prior;
  lane_t raw;

  always_comb begin
    prior = fwd_sel ? fwd_data : rdata;
    raw   = first_pass ? psum : prior + psum;
`ifdef OFMAP_RELU_EN
    sum   = (last_pass && raw[OFMAP_BITWIDTH-1]) ? '0 : raw;
`else
    sum   = raw;
`endif
  end

`ifndef OFMAP_RELU_EN
  logic unused_last;
  assign unused_last = last_pass;
`endif
endmodule

// File: rtl/ofmap_accum_controller.sv
// Read-modify-write accumulator of MAC psum rows into the OFMap SRAM.
// Build with OFMAP_RELU_EN to clamp negative lanes on the last pass.
module ofmap_accum_controller
  import ofmap_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_in,
  input  logic                      first_pass_in,
  input  logic                      last_pass_in,
  input  logic [OFMAP_ADDR_BIT-1:0] o_ch_blk_in,
  input  logic                      mac_valid_in,
  input  logic [ROW_W-1:0]          mac_data_in,
  output logic [OFMAP_ADDR_BIT-1:0] ofmap_raddr_out,
  output logic                      ofmap_read_en_out,
  input  logic [ROW_W-1:0]          ofmap_rdata_in,
  output logic [OFMAP_ADDR_BIT-1:0] ofmap_waddr_out,
  output logic                      ofmap_write_en_out,
  output logic [ROW_W-1:0]          ofmap_wdata_out,
  output logic                      busy_out,
  output logic                      pass_done_out,
  output logic                      seq_err_out
);
  state_t state, state_nxt;
  logic   first_q, last_q;
  addr_t  base_q, cnt_q, pix_addr;
  logic   accept, last_pix;

  logic   s1_valid, fwd_q;
  addr_t  s1_addr;
  row_t   s1_psum, fwd_row_q, sum_row;

  assign pix_addr = base_q + cnt_q;
  assign last_pix = (cnt_q == addr_t'(OFMAP_PIXELS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_in) state_nxt = ACCUM;
      ACCUM:   if (accept && last_pix) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept        = (state == ACCUM) && mac_valid_in;
    busy_out      = (state != IDLE);
    pass_done_out = (state == FLUSH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
      base_q  <= '0;
      cnt_q   <= '0;
    end else if (state == IDLE && start_in) begin
      first_q <= first_pass_in;
      last_q  <= last_pass_in;
      base_q  <= addr_t'(o_ch_blk_in * OFMAP_PIXELS);
      cnt_q   <= '0;
    end else if (accept) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Same-address back-to-back rows: SRAM read would miss the write in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_psum   <= '0;
      fwd_q     <= 1'b0;
      fwd_row_q <= '0;
    end else begin
      s1_valid  <= accept;
      fwd_q     <= accept && s1_valid && (pix_addr == s1_addr);
      fwd_row_q <= ofmap_wdata_out;
      if (accept) begin
        s1_addr <= pix_addr;
        s1_psum <= mac_data_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) seq_err_out <= 1'b0;
    else if ((start_in && state != IDLE) ||
             (mac_valid_in && state != ACCUM))
      seq_err_out <= 1'b1;
  end

  for (genvar i = 0; i < MAC_COL; i++) begin : g_lane
    psum_lane_adder u_add (
      .psum       (lane_of(s1_psum, i)),
      .rdata      (lane_of(ofmap_rdata_in, i)),
      .fwd_data   (lane_of(fwd_row_q, i)),
      .fwd_sel    (fwd_q),
      .first_pass (first_q),
      .last_pass  (last_q),
      .sum        (sum_row[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH])
    );
  end

  assign ofmap_raddr_out    = pix_addr;
  assign ofmap_read_en_out  = accept && !first_q;
  assign ofmap_waddr_out    = s1_addr;
  assign ofmap_write_en_out = s1_valid;
  assign ofmap_wdata_out    = s1_valid ? sum_row : '0;
endmodule

// File: tb/tb_ofmap_accum_controller.sv
// Scoreboard bench: random psum passes against an SRAM-level reference model.
// Expected ReLU behaviour follows OFMAP_RELU_EN.
module tb_ofmap_accum_controller;
  import ofmap_pkg::*;

  localparam int W   = OFMAP_BITWIDTH;
  localparam int PIX = OFMAP_PIXELS;

  logic  clk = 1'b0;
  logic  rst;
  logic  start_in, first_pass_in, last_pass_in;
  addr_t o_ch_blk_in;
  logic  mac_valid_in;
  row_t  mac_data_in;
  addr_t raddr, waddr;
  logic  ren, wen;
  row_t  rdata, wdata;
  logic  busy, done, seq_err;

  ofmap_accum_controller dut (
    .clk                (clk),
    .rst                (rst),
    .start_in           (start_in),
    .first_pass_in      (first_pass_in),
    .last_pass_in       (last_pass_in),
    .o_ch_blk_in        (o_ch_blk_in),
    .mac_valid_in       (mac_valid_in),
    .mac_data_in        (mac_data_in),
    .ofmap_raddr_out    (raddr),
    .ofmap_read_en_out  (ren),
    .ofmap_rdata_in     (rdata),
    .ofmap_waddr_out    (waddr),
    .ofmap_write_en_out (wen),
    .ofmap_wdata_out    (wdata),
    .busy_out           (busy),
    .pass_done_out      (done),
    .seq_err_out        (seq_err)
  );

  always #5 clk = ~clk;

  row_t sram    [0:1023];
  row_t ref_mem [0:1023];

  always @(posedge clk) begin
    if (wen) sram[waddr] <= wdata;
    if (ren) rdata <= sram[raddr];
  end

  typedef struct {
    addr_t addr;
    row_t  data;
    logic  done;
  } wr_t;

  wr_t   wq[$];
  addr_t rq[$];
  int    checks = 0;
  int    failures = 0;
  wr_t   e_mon;
  addr_t a_mon;

  task automatic chk(string name, row_t act, row_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write/read the DUT presents must match the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (wen) begin
        if (wq.size() == 0) chk("unexpected_write", row_t'(wen), '0);
        else begin
          e_mon = wq.pop_front();
          chk("waddr", row_t'(waddr), row_t'(e_mon.addr));
          chk("wdata", wdata, e_mon.data);
          chk("pass_done", row_t'(done), row_t'(e_mon.done));
        end
      end else begin
        chk("pass_done_idle", row_t'(done), '0);
      end
      if (ren) begin
        if (rq.size() == 0) chk("unexpected_read", row_t'(ren), '0);
        else begin
          a_mon = rq.pop_front();
          chk("raddr", row_t'(raddr), row_t'(a_mon));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t gen_row(int mode, int k);
    row_t r;
    for (int i = 0; i < MAC_COL; i++) begin
      lane_t v;
      case (mode)
        0:       v = (k == 0 && i == 0) ? 32'h7FFF_FFFB : lane_t'(k);
        1:       v = 32'd5;
        2:       v = $urandom;
        default: v = lane_t'($urandom_range(0, 40)) - 32'd20;
      endcase
      if (mode == 3 && k == 0 && i == 0) v = lane_t'(-7);
      r[i*W +: W] = v;
    end
    return r;
  endfunction

  // Reference: new = old + psum per lane mod 2^W (or psum on first pass)
  task automatic expect_row(addr_t a, row_t p, bit first, bit last,
                            bit dn);
    row_t e;
    for (int i = 0; i < MAC_COL; i++) begin
      lane_t s;
      s = first ? p[i*W +: W] : ref_mem[a][i*W +: W] + p[i*W +: W];
`ifdef OFMAP_RELU_EN
      if (last && $signed(s) < 0) s = '0;
`endif
      e[i*W +: W] = s;
    end
    ref_mem[a] = e;
    wq.push_back('{a, e, dn});
    if (!first) rq.push_back(a);
  endtask

  task automatic run_pass(int blk, bit first, bit last, int gap_mode,
                          int mode, bit inject);
    int base, t, gap;
    row_t r;
    base = blk * PIX;
    start_in = 1'b1;
    first_pass_in = first;
    last_pass_in = last;
    o_ch_blk_in = addr_t'(blk);
    step();
    start_in = 1'b0;
    first_pass_in = ~first;
    last_pass_in = ~last;
    o_ch_blk_in = addr_t'($urandom);
    chk("busy_after_start", row_t'(busy), 1);
    for (int k = 0; k < PIX; k++) begin
      gap = (gap_mode == 0) ? 0 :
            (gap_mode == 1) ? 2 : int'($urandom_range(0, 2));
      repeat (gap) step();
      r = gen_row(mode, k);
      mac_valid_in = 1'b1;
      mac_data_in = r;
      expect_row(addr_t'(base + k), r, first, last, k == PIX - 1);
      if (inject && k == 50) start_in = 1'b1;
      step();
      mac_valid_in = 1'b0;
      start_in = 1'b0;
      mac_data_in = gen_row(2, 0);
      if (inject && k == 50)
        chk("seq_err_set", row_t'(seq_err), 1);
    end
    t = 0;
    while (busy && t < 8) begin
      step();
      t++;
    end
    chk("flush_len", row_t'(t), 1);
    chk("busy_drop", row_t'(busy), 0);
    chk("queue_drain", row_t'(wq.size() + rq.size()), 0);
  endtask

  initial begin
    lane_t relu_exp;
    rst = 1'b1;
    start_in = 1'b0;
    first_pass_in = 1'b0;
    last_pass_in = 1'b0;
    o_ch_blk_in = '0;
    mac_valid_in = 1'b0;
    mac_data_in = '0;
    for (int c = 0; c < 4; c++) begin
      mac_valid_in = ~mac_valid_in;
      mac_data_in = gen_row(2, 0);
      step();
    end
    mac_valid_in = 1'b0;
    chk("rst_wen", row_t'(wen), 0);
    chk("rst_ren", row_t'(ren), 0);
    chk("rst_busy", row_t'(busy), 0);
    chk("rst_done", row_t'(done), 0);
    chk("rst_err", row_t'(seq_err), 0);
    chk("rst_raddr", row_t'(raddr), 0);
    chk("rst_waddr", row_t'(waddr), 0);
    chk("rst_wdata", wdata, 0);
    rst = 1'b0;
    step();

    run_pass(2, 1'b1, 1'b0, 0, 0, 1'b0);
    run_pass(2, 1'b0, 1'b0, 0, 1, 1'b0);
    chk("wrap_lane0", row_t'(sram[392][31:0]), row_t'(32'h8000_0000));
    chk("wrap_lane1", row_t'(sram[392][63:32]), 5);
    chk("no_err_yet", row_t'(seq_err), 0);

    run_pass(2, 1'b0, 1'b0, 1, 2, 1'b1);
    mac_valid_in = 1'b1;
    mac_data_in = gen_row(2, 0);
    step();
    mac_valid_in = 1'b0;
    step();
    step();
    chk("seq_err_sticky", row_t'(seq_err), 1);
    chk("idle_after_err", row_t'(busy), 0);

    run_pass(2, 1'b0, 1'b1, 2, 2, 1'b0);
    chk("seq_err_sticky2", row_t'(seq_err), 1);

`ifdef OFMAP_RELU_EN
    relu_exp = '0;
`else
    relu_exp = 32'hFFFF_FFF9;
`endif
    run_pass(3, 1'b1, 1'b1, 2, 3, 1'b0);
    chk("relu_last", row_t'(sram[588][31:0]), row_t'(relu_exp));
    run_pass(3, 1'b1, 1'b0, 0, 3, 1'b0);
    chk("relu_notlast", row_t'(sram[588][31:0]),
        row_t'(32'hFFFF_FFF9));

    // Abort mid-pass with a write in flight
    start_in = 1'b1;
    first_pass_in = 1'b1;
    last_pass_in = 1'b0;
    o_ch_blk_in = '0;
    step();
    start_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      mac_valid_in = 1'b1;
      mac_data_in = gen_row(2, 0);
      expect_row(addr_t'(k), mac_data_in, 1'b1, 1'b0, 1'b0);
      step();
    end
    rst = 1'b1;
    #1;
    chk("abort_wen", row_t'(wen), 0);
    chk("abort_ren", row_t'(ren), 0);
    chk("abort_busy", row_t'(busy), 0);
    chk("abort_err", row_t'(seq_err), 0);
    wq.delete();
    rq.delete();
    for (int c = 0; c < 3; c++) begin
      mac_valid_in = ~mac_valid_in;
      step();
      chk("abort_hold_wen", row_t'(wen), 0);
    end
    mac_valid_in = 1'b0;
    rst = 1'b0;
    step();
    run_pass(0, 1'b1, 1'b0, 2, 2, 1'b0);
    chk("err_clear_after_rst", row_t'(seq_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
